// File: rtl/window5x5_gen.sv
// Raster-to-window front end: buffers four image rows and emits every fully populated
// 5x5 neighbourhood, one cycle after the pixel that completes it is accepted.
module window5x5_gen #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic                     sof_in,
  input  logic [DATA_BITS-1:0]     pix_in,
  output logic                     valid_out,
  output logic [25*DATA_BITS-1:0]  win_out,
  output logic                     frame_done
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  logic [ColW-1:0] col_q, col_d, cur_col;
  logic [RowW-1:0] row_q, row_d, cur_row;

  logic [DATA_BITS-1:0] lb0_q [IMG_W];
  logic [DATA_BITS-1:0] lb1_q [IMG_W];
  logic [DATA_BITS-1:0] lb2_q [IMG_W];
  logic [DATA_BITS-1:0] lb3_q [IMG_W];
  logic [DATA_BITS-1:0] new_col [5];

  logic [25*DATA_BITS-1:0] win_q, win_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;

  always_comb begin
    // A start-of-frame pixel is (0,0) no matter where the counters were.
    cur_col = sof_in ? '0 : col_q;
    cur_row = sof_in ? '0 : row_q;

    new_col[0] = lb3_q[cur_col];
    new_col[1] = lb2_q[cur_col];
    new_col[2] = lb1_q[cur_col];
    new_col[3] = lb0_q[cur_col];
    new_col[4] = pix_in;

    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    if (valid_in) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + RowW'(1);
      end else begin
        col_d = cur_col + ColW'(1);
        row_d = cur_row;
      end

      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[(r*5+c)*DATA_BITS +: DATA_BITS] = win_q[(r*5+c+1)*DATA_BITS +: DATA_BITS];
        end
        win_d[(r*5+4)*DATA_BITS +: DATA_BITS] = new_col[r];
      end

      valid_d = (cur_row >= RowW'(4)) && (cur_col >= ColW'(4));
      done_d  = valid_d && (cur_row == RowLast) && (cur_col == ColLast);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Line buffers hold no reset: stale rows can never complete a valid window.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb3_q[cur_col] <= lb2_q[cur_col];
      lb2_q[cur_col] <= lb1_q[cur_col];
      lb1_q[cur_col] <= lb0_q[cur_col];
      lb0_q[cur_col] <= pix_in;
    end
  end

  assign valid_out  = valid_q;
  assign win_out    = win_q;
  assign frame_done = done_q;

endmodule
